// File: rtl/atm_ledger_arbiter.sv
// -----------------------------------------------------------------------------
// atm_ledger_arbiter
//
// Shared account-ledger controller. It owns the per-account balance store and
// serialises balance / withdraw / deposit / transfer operations from NUM_TERM
// terminal front-ends using round-robin arbitration. Every granted operation
// runs IDLE -> LATCH -> EXEC -> RESP. All ledger writes for an operation land
// on the single EXEC->RESP edge, so a transfer is all-or-nothing and a reset
// taken mid-operation can never leave a half-applied transfer behind.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   req         per-terminal request level, held until that terminal's done
//   op          per-terminal opcode at [2t+1:2t]
//               (00 balance, 01 withdraw, 10 deposit, 11 transfer)
//   src_idx     per-terminal source account index, 4 bits per terminal
//   dst_idx     per-terminal destination account index (transfer only)
//   amount      per-terminal amount, AMT_W bits per terminal
//   grant       one-hot, the terminal currently being served
//   done        one-hot, one-cycle pulse, result valid
//   error       operation rejected, ledger unchanged (valid with done)
//   balance_out source balance after the operation (valid with done)
//   busy        high in every state except IDLE
// -----------------------------------------------------------------------------
module atm_ledger_arbiter #(
    parameter int NUM_TERM = 2,
    parameter int NUM_ACC  = 10,
    parameter int BAL_W    = 16,
    parameter int AMT_W    = 11,
    parameter int INIT_BAL = 500
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_TERM-1:0]       req,
    input  logic [2*NUM_TERM-1:0]     op,
    input  logic [4*NUM_TERM-1:0]     src_idx,
    input  logic [4*NUM_TERM-1:0]     dst_idx,
    input  logic [AMT_W*NUM_TERM-1:0] amount,
    output logic [NUM_TERM-1:0]       grant,
    output logic [NUM_TERM-1:0]       done,
    output logic                      error,
    output logic [BAL_W-1:0]          balance_out,
    output logic                      busy
);

    localparam int               TW        = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;
    localparam int               EW        = BAL_W + 1;
    localparam logic [4:0]       ACC_LIMIT = 5'(NUM_ACC);
    localparam logic [BAL_W-1:0] INIT_VAL  = BAL_W'(INIT_BAL);
    localparam logic [TW-1:0]    LAST_TERM = TW'(NUM_TERM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Balance store
    logic [BAL_W-1:0] ledger [NUM_ACC];

    // Registered copy of the winning terminal's request
    logic [NUM_TERM-1:0] grant_r;
    logic [NUM_TERM-1:0] done_r;
    logic [TW-1:0]       win_r;
    logic [TW-1:0]       last_r;
    logic [1:0]          op_r;
    logic [3:0]          src_r;
    logic [3:0]          dst_r;
    logic [AMT_W-1:0]    amt_r;

    // Working registers filled in LATCH
    logic [BAL_W-1:0]    src_bal;
    logic [BAL_W-1:0]    dst_bal;
    logic                src_oob;
    logic                dst_oob;

    // Result registers, held until the next RESP
    logic                error_r;
    logic [BAL_W-1:0]    bal_out_r;

    // Per-terminal views of the packed request fields
    logic [1:0]          op_arr  [NUM_TERM];
    logic [3:0]          src_arr [NUM_TERM];
    logic [3:0]          dst_arr [NUM_TERM];
    logic [AMT_W-1:0]    amt_arr [NUM_TERM];

    for (genvar t = 0; t < NUM_TERM; t++) begin : g_unpack
        assign op_arr[t]  = op[2*t +: 2];
        assign src_arr[t] = src_idx[4*t +: 4];
        assign dst_arr[t] = dst_idx[4*t +: 4];
        assign amt_arr[t] = amount[AMT_W*t +: AMT_W];
    end

    // Round-robin pick. Candidates are scanned from the farthest to the nearest
    // position after the last winner, so the nearest requester overwrites any
    // earlier hit and ends up with the grant.
    logic          arb_valid;
    logic [TW-1:0] arb_idx;
    logic [TW-1:0] arb_cand;

    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int k = NUM_TERM; k >= 1; k--) begin
            arb_cand = TW'((int'(last_r) + k) % NUM_TERM);
            if (req[arb_cand]) begin
                arb_valid = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    // Index range checks for the latched request
    logic src_in_range;
    logic dst_in_range;

    assign src_in_range = ({1'b0, src_r} < ACC_LIMIT);
    assign dst_in_range = ({1'b0, dst_r} < ACC_LIMIT);

    // Operation evaluation in BAL_W+1 bits: the top bit of the sum flags an
    // overflow past 2^BAL_W-1 and the top bit of the difference flags a
    // withdrawal larger than the balance.
    logic [EW-1:0]    amt_ext;
    logic [EW-1:0]    src_sum;
    logic [EW-1:0]    src_diff;
    logic [EW-1:0]    dst_sum;
    logic             exec_err;
    logic             wr_src;
    logic             wr_dst;
    logic [BAL_W-1:0] new_src;
    logic [BAL_W-1:0] new_dst;
    logic [BAL_W-1:0] exec_bal;

    always_comb begin
        amt_ext  = EW'(amt_r);
        src_sum  = {1'b0, src_bal} + amt_ext;
        src_diff = {1'b0, src_bal} - amt_ext;
        dst_sum  = {1'b0, dst_bal} + amt_ext;
        exec_err = 1'b0;
        wr_src   = 1'b0;
        wr_dst   = 1'b0;
        new_src  = src_bal;
        new_dst  = dst_bal;
        case (op_r)
            2'b00: begin
                exec_err = src_oob;
            end
            2'b01: begin
                if (src_oob || src_diff[BAL_W]) begin
                    exec_err = 1'b1;
                end else begin
                    wr_src  = 1'b1;
                    new_src = src_diff[BAL_W-1:0];
                end
            end
            2'b10: begin
                if (src_oob || src_sum[BAL_W]) begin
                    exec_err = 1'b1;
                end else begin
                    wr_src  = 1'b1;
                    new_src = src_sum[BAL_W-1:0];
                end
            end
            default: begin
                if (src_oob || dst_oob || (src_r == dst_r) ||
                    src_diff[BAL_W] || dst_sum[BAL_W]) begin
                    exec_err = 1'b1;
                end else begin
                    wr_src  = 1'b1;
                    wr_dst  = 1'b1;
                    new_src = src_diff[BAL_W-1:0];
                    new_dst = dst_sum[BAL_W-1:0];
                end
            end
        endcase
        exec_bal = src_oob ? '0 : new_src;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a fixed four-cycle walk once a request is accepted
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = arb_valid ? LATCH : IDLE;
            LATCH:   state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and ledger. The winner's fields are captured once in IDLE, so
    // later changes on that terminal's inputs cannot affect the operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                ledger[i] <= INIT_VAL;
            end
            grant_r   <= '0;
            done_r    <= '0;
            win_r     <= '0;
            last_r    <= LAST_TERM;
            op_r      <= '0;
            src_r     <= '0;
            dst_r     <= '0;
            amt_r     <= '0;
            src_bal   <= '0;
            dst_bal   <= '0;
            src_oob   <= 1'b0;
            dst_oob   <= 1'b0;
            error_r   <= 1'b0;
            bal_out_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant_r <= NUM_TERM'(1) << arb_idx;
                        win_r   <= arb_idx;
                        op_r    <= op_arr[arb_idx];
                        src_r   <= src_arr[arb_idx];
                        dst_r   <= dst_arr[arb_idx];
                        amt_r   <= amt_arr[arb_idx];
                    end
                end
                LATCH: begin
                    src_bal <= src_in_range ? ledger[src_r] : '0;
                    dst_bal <= dst_in_range ? ledger[dst_r] : '0;
                    src_oob <= !src_in_range;
                    dst_oob <= !dst_in_range;
                end
                EXEC: begin
                    if (wr_src) begin
                        ledger[src_r] <= new_src;
                    end
                    if (wr_dst) begin
                        ledger[dst_r] <= new_dst;
                    end
                    error_r   <= exec_err;
                    bal_out_r <= exec_bal;
                    done_r    <= grant_r;
                end
                RESP: begin
                    done_r  <= '0;
                    grant_r <= '0;
                    last_r  <= win_r;
                end
                default: begin
                    done_r  <= '0;
                    grant_r <= '0;
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign done        = done_r;
    assign error       = error_r;
    assign balance_out = bal_out_r;
    assign busy        = (state != IDLE);

endmodule
